// File: rtl/adder_arbiter.sv
// adder_arbiter
//
// Round-robin arbiter in front of one shared WIDTH-bit ripple-carry adder.
// N requesters offer {a, b, ci}; one is granted per accepted transaction and
// its sum, carry-out and index land in a single-entry response stage.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Ready never depends on the same side's valid through a loop;
// req_ready is a function of req_valid, ptr and the response stage occupancy.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [N]        per-requester request present
//   req_ready  [N]        one-hot (or zero) grant/accept this cycle
//   req_a      [N*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      [N*WIDTH]  operand b, same packing
//   req_ci     [N]        carry-in per requester
//   rsp_valid             response stage holds a result
//   rsp_ready             consumer takes the response
//   rsp_id     [IDW]      requester index that produced the result
//   rsp_s      [WIDTH]    sum
//   rsp_co                carry-out
//   done_cnt   [16]       completed responses, wraps silently

// Plain ripple-carry adder: carry propagates bit by bit from ci.
module adder_structure #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s,
    output logic             co
);
    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module adder_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int N     = 4,
    localparam int IDW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       req_valid,
    output logic [N-1:0]       req_ready,
    input  logic [N*WIDTH-1:0] req_a,
    input  logic [N*WIDTH-1:0] req_b,
    input  logic [N-1:0]       req_ci,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [WIDTH-1:0]   rsp_s,
    output logic               rsp_co,
    output logic [15:0]        done_cnt
);
    // Response stage occupancy: rsp_valid is the decoded state.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   winner;
    logic             found;
    logic             free;
    logic             accept;
    logic [N-1:0]     grant_vec;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             sel_ci;
    logic [WIDTH-1:0] sum_s;
    logic             sum_co;

    assign rsp_valid = (state == FULL);
    assign free      = !rsp_valid || rsp_ready;

    // Round-robin search starting at ptr, wrapping mod N.
    always_comb begin
        int             idx;
        logic [IDW-1:0] cand;
        idx    = 0;
        cand   = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            cand = IDW'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // A grant is only ever given to a valid requester, so granting is accepting.
    assign accept = found && free;

    always_comb begin
        grant_vec = '0;
        grant_vec[winner] = 1'b1;
    end

    // rst_n only gates the visible ready; internal state is held by the reset.
    assign req_ready = (accept && rst_n) ? grant_vec : '0;

    // Operand mux feeding the single shared adder.
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_ci = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (winner == IDW'(i)) begin
                sel_a  = req_a[i*WIDTH +: WIDTH];
                sel_b  = req_b[i*WIDTH +: WIDTH];
                sel_ci = req_ci[i];
            end
        end
    end

    adder_structure #(.WIDTH(WIDTH)) u_adder (
        .a  (sel_a),
        .b  (sel_b),
        .ci (sel_ci),
        .s  (sum_s),
        .co (sum_co)
    );

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_s  <= '0;
            rsp_co <= 1'b0;
            rsp_id <= '0;
            ptr    <= '0;
        end else if (accept) begin
            rsp_s  <= sum_s;
            rsp_co <= sum_co;
            rsp_id <= winner;
            ptr    <= (winner == IDW'(N-1)) ? '0 : winner + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (rsp_valid && rsp_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter (WIDTH=32, N=4): reset check, table of arbitration
// vectors, hand-written sequences for single request, backpressure and
// asynchronous reset, a random-operand scoreboard and a done_cnt wrap run.
module tb_adder_arbiter;
    localparam int WIDTH = 32;
    localparam int N     = 4;
    localparam int IDW   = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*WIDTH-1:0] req_a;
    logic [N*WIDTH-1:0] req_b;
    logic [N-1:0]       req_ci;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [WIDTH-1:0]   rsp_s;
    logic               rsp_co;
    logic [15:0]        done_cnt;

    logic [WIDTH-1:0] op_a [N];
    logic [WIDTH-1:0] op_b [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*WIDTH +: WIDTH] = op_a[i];
            req_b[i*WIDTH +: WIDTH] = op_b[i];
        end
    end

    adder_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ci    (req_ci),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_co    (rsp_co),
        .done_cnt  (done_cnt)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_done;
    logic [IDW+WIDTH:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_std_operands();
        for (int i = 0; i < N; i++) begin
            op_a[i]   = WIDTH'(i);
            op_b[i]   = 32'h10;
            req_ci[i] = 1'b1;
        end
    endtask

    task automatic drive(input logic [N-1:0] v, input logic rdy);
        @(negedge clk);
        req_valid = v;
        rsp_ready = rdy;
        #1;
    endtask

    task automatic to_after_edge();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0]     valid;
        logic             rdy;
        logic [N-1:0]     exp_ready;
        logic             exp_rv;
        logic [IDW-1:0]   exp_id;
        logic [WIDTH-1:0] exp_s;
    } vec_t;

    vec_t vecs[17];

    initial begin
        logic prev_rv;
        logic model_rv;
        logic exp_acc;
        logic [N-1:0] vmask;
        logic [IDW+WIDTH:0] e;
        logic [WIDTH:0] sum;
        logic [IDW-1:0] rid;
        int r;
        logic v;
        logic rdy;

        // Operands: requester i -> a=i, b=0x10, ci=1, so sum = 0x11+i.
        vecs[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11};
        vecs[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h12};
        vecs[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h13};
        vecs[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h14};
        vecs[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11};
        vecs[5]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h11};
        vecs[6]  = '{4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3, 32'h14};
        vecs[7]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h14};
        vecs[8]  = '{4'b1001, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h14};
        vecs[9]  = '{4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h11};
        vecs[10] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h11};
        vecs[11] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 32'h13};
        vecs[12] = '{4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h12};
        vecs[13] = '{4'b0000, 1'b0, 4'b0000, 1'b1, 2'd1, 32'h12};
        vecs[14] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1, 32'h12};
        vecs[15] = '{4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h11};
        vecs[16] = '{4'b0011, 1'b1, 4'b0010, 1'b1, 2'd1, 32'h12};

        // ---- reset: 3 cycles low, requests present ----
        set_std_operands();
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_s", 64'(rsp_s), 64'd0);
        check("reset_rsp_co", 64'(rsp_co), 64'd0);
        check("reset_rsp_id", 64'(rsp_id), 64'd0);
        check("reset_done_cnt", 64'(done_cnt), 64'd0);
        check("reset_req_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        exp_done  = '0;

        // ---- table-driven arbitration vectors ----
        prev_rv = 1'b0;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].rdy);
            check($sformatf("vec%0d_req_ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
            if (prev_rv && vecs[i].rdy) exp_done++;
            to_after_edge();
            check($sformatf("vec%0d_rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].exp_rv));
            if (vecs[i].exp_rv) begin
                check($sformatf("vec%0d_rsp_id", i), 64'(rsp_id), 64'(vecs[i].exp_id));
                check($sformatf("vec%0d_rsp_s", i), 64'(rsp_s), 64'(vecs[i].exp_s));
                check($sformatf("vec%0d_rsp_co", i), 64'(rsp_co), 64'd0);
            end
            check($sformatf("vec%0d_done_cnt", i), 64'(done_cnt), 64'(exp_done));
            prev_rv = vecs[i].exp_rv;
        end

        // ---- single request from requester 2 (ptr now 2, stage full) ----
        op_a[2]   = 32'hFFFF_FFFF;
        op_b[2]   = 32'h0000_0001;
        req_ci[2] = 1'b0;
        drive(4'b0100, 1'b1);
        check("single_req_ready", 64'(req_ready), 64'b0100);
        exp_done++;
        to_after_edge();
        check("single_rsp_valid", 64'(rsp_valid), 64'd1);
        check("single_rsp_s", 64'(rsp_s), 64'h0);
        check("single_rsp_co", 64'(rsp_co), 64'd1);
        check("single_rsp_id", 64'(rsp_id), 64'd2);
        drive(4'b0000, 1'b1);
        exp_done++;
        to_after_edge();
        check("single_drain_valid", 64'(rsp_valid), 64'd0);
        check("single_done_cnt", 64'(done_cnt), 64'(exp_done));
        set_std_operands();

        // ---- backpressure: ptr=3, stage empty ----
        drive(4'b1111, 1'b0);
        check("bp_first_ready", 64'(req_ready), 64'b1000);
        to_after_edge();
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b0);
            check($sformatf("bp%0d_req_ready", i), 64'(req_ready), 64'd0);
            to_after_edge();
            check($sformatf("bp%0d_rsp_valid", i), 64'(rsp_valid), 64'd1);
            check($sformatf("bp%0d_rsp_id", i), 64'(rsp_id), 64'd3);
            check($sformatf("bp%0d_rsp_s", i), 64'(rsp_s), 64'h14);
        end
        drive(4'b1111, 1'b1);
        check("bp_release_ready", 64'(req_ready), 64'b0001);
        exp_done++;
        to_after_edge();
        check("bp_release_id", 64'(rsp_id), 64'd0);
        check("bp_release_s", 64'(rsp_s), 64'h11);
        check("bp_done_cnt", 64'(done_cnt), 64'(exp_done));

        // ---- reset mid-operation with a full, stalled stage ----
        drive(4'b0010, 1'b1);
        check("mid_grant1_ready", 64'(req_ready), 64'b0010);
        to_after_edge();
        drive(4'b1001, 1'b0);
        check("mid_stall_ready", 64'(req_ready), 64'd0);
        to_after_edge();
        check("mid_full_before_reset", 64'(rsp_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_reset_req_ready", 64'(req_ready), 64'd0);
        check("mid_reset_rsp_id", 64'(rsp_id), 64'd0);
        check("mid_reset_done_cnt", 64'(done_cnt), 64'd0);
        exp_done = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        rsp_ready = 1'b1;
        #1;
        check("post_reset_ready", 64'(req_ready), 64'b0001);
        to_after_edge();
        check("post_reset_id", 64'(rsp_id), 64'd0);
        check("post_reset_s", 64'(rsp_s), 64'h11);

        // ---- random-operand scoreboard, one requester at a time ----
        exp_q.delete();
        exp_q.push_back({2'd0, 33'h0_0000_0011});
        model_rv = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            r   = $urandom_range(0, N-1);
            v   = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            op_a[r]   = $urandom;
            op_b[r]   = $urandom;
            req_ci[r] = 1'($urandom_range(0, 1));
            vmask     = '0;
            vmask[r]  = v;
            req_valid = vmask;
            rsp_ready = rdy;
            #1;
            exp_acc = v && (!model_rv || rdy);
            check("rnd_req_ready", 64'(req_ready), 64'(exp_acc ? vmask : 4'b0000));
            if (model_rv && rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rnd_queue_underflow actual=empty expected=entry");
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_response", 64'({rsp_id, rsp_co, rsp_s}), 64'(e));
                end
                exp_done++;
            end
            if (exp_acc) begin
                rid = r[IDW-1:0];
                sum = {1'b0, op_a[r]} + {1'b0, op_b[r]} + {{WIDTH{1'b0}}, req_ci[r]};
                exp_q.push_back({rid, sum});
            end
            model_rv = exp_acc || (model_rv && !rdy);
        end
        drive(4'b0000, 1'b1);
        if (model_rv) begin
            e = exp_q.pop_front();
            check("rnd_final_response", 64'({rsp_id, rsp_co, rsp_s}), 64'(e));
            exp_done++;
        end
        to_after_edge();
        check("rnd_done_cnt", 64'(done_cnt), 64'(exp_done));
        check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
        check("rnd_drained", 64'(rsp_valid), 64'd0);

        // ---- done_cnt wrap: 65536 back-to-back transactions ----
        @(negedge clk);
        rst_n = 1'b0;
        set_std_operands();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 65536; n++) begin
            drive(4'b0001, 1'b1);
        end
        drive(4'b0000, 1'b1);
        check("wrap_before_last", 64'(done_cnt), 64'hFFFF);
        to_after_edge();
        check("wrap_done_cnt", 64'(done_cnt), 64'h0000);
        check("wrap_rsp_valid", 64'(rsp_valid), 64'd0);

        // ---- final report ----
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one WIDTH-bit ripple-carry adder (`adder_structure`) between N requesters. Each requester offers operands `a`, `b` and carry-in `ci` over a valid/ready handshake. The block grants one requester per accepted transaction and registers the sum, carry-out and requester ID into a single-entry response stage. It sits between the compute clients and the shared adder datapath and is the only driver of that adder's inputs.

## Interface
- `WIDTH`, 32: operand and sum width, ≥1.
- `N`, 4: number of requesters, 2..16.
- `IDW`, `$clog2(N)`: requester-ID width (derived, not overridden).

- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N  bit i: requester i presents an operation.
- `req_ready`  out  N  bit i: requester i's operation accepted this cycle; one-hot or zero.
- `req_a`  in  N*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH].
- `req_b`  in  N*WIDTH  operand b, same packing.
- `req_ci`  in  N  carry-in per requester.
- `rsp_valid`  out  1  response stage holds a result.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `rsp_s`  out  WIDTH  sum.
- `rsp_co`  out  1  carry-out.
- `done_cnt`  out  16  completed responses, wraps at 2^16.

## Operation
- Response stage: one entry. States are EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
- Free condition: `free = !rsp_valid | rsp_ready`.
- Arbitration is combinational from `req_valid` and priority pointer `ptr` (IDW bits).
  - Search order: ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - The first requester with valid set is the winner.
- `req_ready[w]` = 1 only for winner w and only when `free`. All other ready bits are 0. No grant when no valid or not `free`.
- On accept (`req_valid[w] & req_ready[w]`):
  - The adder computes {co, s} = a_w + b_w + ci_w, truncated to WIDTH+1 bits.
  - `rsp_s`, `rsp_co` and `rsp_id` = w are registered.
  - `rsp_valid` ← 1.
  - `ptr` ← (w+1) mod N.
- On `rsp_valid & rsp_ready`:
  - `done_cnt` ← `done_cnt` + 1.
  - If there is no simultaneous accept, `rsp_valid` ← 0.
  - A simultaneous accept overwrites the entry; `rsp_valid` stays 1.
- While `rsp_valid & !rsp_ready`: `rsp_s`, `rsp_co` and `rsp_id` are held stable. No requester is granted and `ptr` is unchanged.
- `ptr` changes only on accept. An idle cycle never moves it.
- A requester may drop `req_valid` without being accepted. The block keeps no per-request state.
- Reset (asynchronous, any time, including with a full response stage):
  - `rsp_valid`=0, `rsp_s`=0, `rsp_co`=0, `rsp_id`=0, `done_cnt`=0, `ptr`=0.
  - Any pending response is discarded.
  - `req_ready`=0 while `rst_n`=0.

## Timing
- Latency: accept in cycle T → `rsp_valid`=1 with the result in cycle T+1.
- Throughput: one operation per cycle when `rsp_ready` is held high.
- The adder path is combinational from the muxed request operands to the response registers. The critical path is the arbitration mux followed by the WIDTH-bit ripple.
- `req_ready` depends combinationally on `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`. No ready depends on its own valid through a loop.
- `done_cnt` wraps 0xFFFF → 0x0000 with no flag.

## Test plan
- **Reset:** pulse `rst_n` low for 3 cycles → all outputs 0, `req_ready`=0, `done_cnt`=0.
- **Single request:** requester 2 issues a=0xFFFFFFFF, b=0x00000001, ci=0, with `rsp_ready`=1 → next cycle `rsp_valid`=1, `rsp_s`=0x00000000, `rsp_co`=1, `rsp_id`=2, then `done_cnt`=1.
- **Round-robin fairness:** all 4 valid continuously, `rsp_ready`=1, each requester i sends a=i, b=0x10, ci=1 → `rsp_id` sequence 0,1,2,3,0,…; `rsp_s` = 0x11+i; one response per cycle.
- **Backpressure:** `rsp_ready`=0 for 5 cycles with the stage FULL → `rsp_*` stable, `req_ready`=0, `ptr` frozen. Release `rsp_ready` → the next grant goes to the correct next requester in the same cycle.
- **Reset mid-operation:** `rsp_valid`=1 with `rsp_ready`=0, then assert `rst_n`=0 asynchronously → `rsp_valid` drops immediately and `ptr`=0. After release, requester 0 wins over 3 when both are valid.
- **Counter wrap:** preload by running 65536 transactions → `done_cnt` returns to 0x0000. Random-operand scoreboard over 10k ops: `{rsp_co, rsp_s}` = a+b+ci on every response.
